// File: rtl/ibex_rf_wport_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
//   rf_wr_req_t    : one buffered ID/EX write {addr, data}
//   rf_wport_sel_e : which source owns the RF write port this cycle
package ibex_rf_wport_arbiter_pkg;

   localparam int unsigned RegAddrW = 5;
   localparam int unsigned DataW    = 32;
   localparam int unsigned ReqW     = RegAddrW + DataW;

   typedef struct packed {
      logic [RegAddrW-1:0] addr;
      logic [DataW-1:0]    data;
   } rf_wr_req_t;

   typedef enum logic [1:0] {
      WPORT_NONE,
      WPORT_LSU,
      WPORT_IDBUF,
      WPORT_IDDIR
   } rf_wport_sel_e;

endpackage

// File: rtl/ibex_rf_wport_arbiter_if.sv
// Request-side bundle of the write-port arbiter: the ID/EX write channel and
// the LSU load issue/response channel.
//   master : ID/EX and LSU side (drives requests, sees ready)
//   slave  : arbiter side
// Handshake: a transfer on a valid/ready pair happens in a cycle where both
// are high; ready never depends on valid of the same channel. The LSU
// response is not stallable and carries no ready.
interface ibex_rf_wport_arbiter_if;
   import ibex_rf_wport_arbiter_pkg::*;

   logic                id_wr_valid;
   logic                id_wr_ready;
   logic [RegAddrW-1:0] id_wr_addr;
   logic [DataW-1:0]    id_wr_data;
   logic                lsu_load_issue;
   logic [RegAddrW-1:0] lsu_load_addr;
   logic                lsu_load_ready;
   logic                lsu_resp_valid;
   logic                lsu_resp_err;
   logic [DataW-1:0]    lsu_rdata;

   modport master (
      output id_wr_valid, id_wr_addr, id_wr_data,
      output lsu_load_issue, lsu_load_addr,
      output lsu_resp_valid, lsu_resp_err, lsu_rdata,
      input  id_wr_ready, lsu_load_ready
   );

   modport slave (
      input  id_wr_valid, id_wr_addr, id_wr_data,
      input  lsu_load_issue, lsu_load_addr,
      input  lsu_resp_valid, lsu_resp_err, lsu_rdata,
      output id_wr_ready, lsu_load_ready
   );

endinterface

// File: rtl/ibex_wport_fifo.sv
// Small circular FIFO used for the load destination queue and the ID/EX
// write buffer. Besides the head it exposes every slot (valid + data) so the
// parent can build a pending-write scoreboard.
//   push_i/push_data_i : enqueue (caller guarantees ~full_o)
//   pop_i              : dequeue head (caller guarantees ~empty_o)
//   full_o/empty_o/level_o/head_o : occupancy and oldest entry
//   entry_valid_o/entry_data_o    : per-slot state, slot i at [i*Width +: Width]
module ibex_wport_fifo #(
   parameter int unsigned Width = 5,
   parameter int unsigned Depth = 2,
   localparam int unsigned LvlW = $clog2(Depth + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [Width-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [LvlW-1:0]        level_o,
   output logic [Width-1:0]       head_o,
   output logic [Depth-1:0]       entry_valid_o,
   output logic [Depth*Width-1:0] entry_data_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem_q [Depth];
   logic [Depth-1:0] vld_q;
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LvlW-1:0]  level_q;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         // Push only lands in a free slot, so it never collides with the
         // popped slot; clearing first keeps the ordering obvious.
         if (pop_i) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= ptr_inc(rd_ptr_q);
         end
         if (push_i) begin
            vld_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         level_q <= level_q + LvlW'(push_i) - LvlW'(pop_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign full_o        = (level_q == LvlW'(Depth));
   assign empty_o       = (level_q == '0);
   assign level_o       = level_q;
   assign head_o        = mem_q[rd_ptr_q];
   assign entry_valid_o = vld_q;

   for (genvar g = 0; g < Depth; g++) begin : g_flat
      assign entry_data_o[g*Width +: Width] = mem_q[g];
   end

endmodule

// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter. Each cycle the single RF write port goes
// to, in priority order: a good LSU load response (non-stallable), the head
// of the ID/EX write buffer, or a direct ID/EX write when the buffer is empty.
// ID/EX writes that lose the port are buffered in order. Destinations of
// outstanding loads and buffered writes form a pending mask used for RAW
// hazard flags.
//   clk_i, rst_ni        : clock, async active-low reset
//   bus                  : ID/EX write + LSU issue/response channels
//   rf_we_o/waddr/wdata  : RF write port
//   rd_addr_a_i/b_i      : ID read addresses; hazard_a_o/b_o flag pending regs
//   pending_mask_o       : registers with a queued or outstanding write
//   id_buf_level_o       : ID buffer occupancy
//   protocol_err_o       : sticky, load response seen with no load outstanding
module ibex_rf_wport_arbiter
   import ibex_rf_wport_arbiter_pkg::*;
#(
   parameter int unsigned IdBufDepth = 2,
   parameter int unsigned MaxLoads   = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   ibex_rf_wport_arbiter_if.slave           bus,
   output logic                             rf_we_o,
   output logic [RegAddrW-1:0]              rf_waddr_o,
   output logic [DataW-1:0]                 rf_wdata_o,
   input  logic [RegAddrW-1:0]              rd_addr_a_i,
   input  logic [RegAddrW-1:0]              rd_addr_b_i,
   output logic                             hazard_a_o,
   output logic                             hazard_b_o,
   output logic [31:0]                      pending_mask_o,
   output logic [$clog2(IdBufDepth+1)-1:0]  id_buf_level_o,
   output logic                             protocol_err_o
);

   logic                         lq_push, lq_pop, lq_full, lq_empty;
   logic [RegAddrW-1:0]          lq_head;
   logic [$clog2(MaxLoads+1)-1:0] lq_level;
   logic [MaxLoads-1:0]          lq_vld;
   logic [MaxLoads*RegAddrW-1:0] lq_flat;

   logic                         ib_push, ib_pop, ib_full, ib_empty;
   rf_wr_req_t                   ib_head;
   logic [IdBufDepth-1:0]        ib_vld;
   logic [IdBufDepth*ReqW-1:0]   ib_flat;

   rf_wport_sel_e                sel;
   logic                         id_acc, lsu_wr;
   logic                         perr_q;
   logic [31:0]                  pending_mask;

   // Ready is taken from pre-pop occupancy: a full buffer refuses even if
   // its head drains this cycle.
   assign bus.id_wr_ready    = ~ib_full;
   assign bus.lsu_load_ready = ~lq_full;
   assign id_acc             = bus.id_wr_valid & ~ib_full;

   // Any response retires the oldest load; only a good one writes the RF.
   assign lq_pop  = bus.lsu_resp_valid & ~lq_empty;
   assign lsu_wr  = lq_pop & ~bus.lsu_resp_err;
   assign lq_push = bus.lsu_load_issue & ~lq_full;

   always_comb begin
      sel = WPORT_NONE;
      if (lsu_wr)         sel = WPORT_LSU;
      else if (!ib_empty) sel = WPORT_IDBUF;
      else if (id_acc)    sel = WPORT_IDDIR;
   end

   assign ib_pop  = (sel == WPORT_IDBUF);
   assign ib_push = id_acc & (sel != WPORT_IDDIR);

   always_comb begin
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      unique case (sel)
         WPORT_LSU: begin
            rf_waddr_o = lq_head;
            rf_wdata_o = bus.lsu_rdata;
         end
         WPORT_IDBUF: begin
            rf_waddr_o = ib_head.addr;
            rf_wdata_o = ib_head.data;
         end
         WPORT_IDDIR: begin
            rf_waddr_o = bus.id_wr_addr;
            rf_wdata_o = bus.id_wr_data;
         end
         default: ;
      endcase
   end

   // x0 writes retire their entry but never reach the RF.
   assign rf_we_o = (sel != WPORT_NONE) && (rf_waddr_o != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                            perr_q <= 1'b0;
      else if (bus.lsu_resp_valid && lq_empty) perr_q <= 1'b1;
   end
   assign protocol_err_o = perr_q;

   // Built from queue state only, so ID's hazard check has no path from
   // this cycle's LSU/ID inputs.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < MaxLoads; i++) begin
         if (lq_vld[i]) pending_mask[lq_flat[i*RegAddrW +: RegAddrW]] = 1'b1;
      end
      for (int i = 0; i < IdBufDepth; i++) begin
         if (ib_vld[i]) pending_mask[ib_flat[i*ReqW + DataW +: RegAddrW]] = 1'b1;
      end
      pending_mask[0] = 1'b0;
   end

   assign pending_mask_o = pending_mask;
   assign hazard_a_o     = pending_mask[rd_addr_a_i];
   assign hazard_b_o     = pending_mask[rd_addr_b_i];

   ibex_wport_fifo #(.Width(RegAddrW), .Depth(MaxLoads)) u_load_q (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .push_i        (lq_push),
      .push_data_i   (bus.lsu_load_addr),
      .pop_i         (lq_pop),
      .full_o        (lq_full),
      .empty_o       (lq_empty),
      .level_o       (lq_level),
      .head_o        (lq_head),
      .entry_valid_o (lq_vld),
      .entry_data_o  (lq_flat)
   );

   ibex_wport_fifo #(.Width(ReqW), .Depth(IdBufDepth)) u_id_buf (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .push_i        (ib_push),
      .push_data_i   ({bus.id_wr_addr, bus.id_wr_data}),
      .pop_i         (ib_pop),
      .full_o        (ib_full),
      .empty_o       (ib_empty),
      .level_o       (id_buf_level_o),
      .head_o        (ib_head),
      .entry_valid_o (ib_vld),
      .entry_data_o  (ib_flat)
   );

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
module tb_ibex_rf_wport_arbiter;

   logic        clk_i;
   logic        rst_ni;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic [4:0]  rd_addr_a_i, rd_addr_b_i;
   logic        hazard_a_o, hazard_b_o;
   logic [31:0] pending_mask_o;
   logic [1:0]  id_buf_level_o;
   logic        protocol_err_o;

   ibex_rf_wport_arbiter_if bus ();

   ibex_rf_wport_arbiter #(.IdBufDepth(2), .MaxLoads(2)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .bus            (bus),
      .rf_we_o        (rf_we_o),
      .rf_waddr_o     (rf_waddr_o),
      .rf_wdata_o     (rf_wdata_o),
      .rd_addr_a_i    (rd_addr_a_i),
      .rd_addr_b_i    (rd_addr_b_i),
      .hazard_a_o     (hazard_a_o),
      .hazard_b_o     (hazard_b_o),
      .pending_mask_o (pending_mask_o),
      .id_buf_level_o (id_buf_level_o),
      .protocol_err_o (protocol_err_o)
   );

   // ---------------- clock / reset ----------------
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // ---------------- scoreboard ----------------
   logic [36:0] exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic        id_v;  logic [4:0] id_a;  logic [31:0] id_d;
      logic        iss;   logic [4:0] iss_a;
      logic        rv;    logic       re;    logic [31:0] rd;
      logic [4:0]  ra;    logic [4:0] rb;
      logic        e_we;  logic [4:0] e_wa;  logic [31:0] e_wd;
      logic        e_idr; logic       e_ldr; logic [31:0] e_mask;
      logic        e_ha;  logic       e_hb;  logic [1:0]  e_lvl; logic e_perr;
   } vec_t;

   function automatic vec_t mk(
      input logic id_v, input logic [4:0] id_a, input logic [31:0] id_d,
      input logic iss, input logic [4:0] iss_a,
      input logic rv, input logic re, input logic [31:0] rd,
      input logic [4:0] ra, input logic [4:0] rb,
      input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
      input logic e_idr, input logic e_ldr, input logic [31:0] e_mask,
      input logic e_ha, input logic e_hb, input logic [1:0] e_lvl, input logic e_perr);
      vec_t v;
      v.id_v = id_v; v.id_a = id_a; v.id_d = id_d; v.iss = iss; v.iss_a = iss_a;
      v.rv = rv; v.re = re; v.rd = rd; v.ra = ra; v.rb = rb;
      v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_idr = e_idr; v.e_ldr = e_ldr;
      v.e_mask = e_mask; v.e_ha = e_ha; v.e_hb = e_hb; v.e_lvl = e_lvl; v.e_perr = e_perr;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      bus.id_wr_valid = 1'b0; bus.id_wr_addr = '0; bus.id_wr_data = '0;
      bus.lsu_load_issue = 1'b0; bus.lsu_load_addr = '0;
      bus.lsu_resp_valid = 1'b0; bus.lsu_resp_err = 1'b0; bus.lsu_rdata = '0;
      rd_addr_a_i = '0; rd_addr_b_i = '0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      logic [36:0] w;
      @(posedge clk_i); #1;
      bus.id_wr_valid = v.id_v; bus.id_wr_addr = v.id_a; bus.id_wr_data = v.id_d;
      bus.lsu_load_issue = v.iss; bus.lsu_load_addr = v.iss_a;
      bus.lsu_resp_valid = v.rv; bus.lsu_resp_err = v.re; bus.lsu_rdata = v.rd;
      rd_addr_a_i = v.ra; rd_addr_b_i = v.rb;
      if (v.e_we) exp_q.push_back({v.e_wa, v.e_wd});
      @(negedge clk_i);
      chk($sformatf("v%0d rf_we", idx), 32'(rf_we_o), 32'(v.e_we));
      if (rf_we_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL v%0d unexpected_write: got x%0d=0x%0h expected none", idx, rf_waddr_o, rf_wdata_o);
         end else begin
            w = exp_q.pop_front();
            chk($sformatf("v%0d waddr", idx), 32'(rf_waddr_o), 32'(w[36:32]));
            chk($sformatf("v%0d wdata", idx), rf_wdata_o, w[31:0]);
         end
      end else if (v.e_we && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
      end
      chk($sformatf("v%0d id_ready", idx), 32'(bus.id_wr_ready), 32'(v.e_idr));
      chk($sformatf("v%0d load_ready", idx), 32'(bus.lsu_load_ready), 32'(v.e_ldr));
      chk($sformatf("v%0d mask", idx), pending_mask_o, v.e_mask);
      chk($sformatf("v%0d haz_a", idx), 32'(hazard_a_o), 32'(v.e_ha));
      chk($sformatf("v%0d haz_b", idx), 32'(hazard_b_o), 32'(v.e_hb));
      chk($sformatf("v%0d level", idx), 32'(id_buf_level_o), 32'(v.e_lvl));
      chk($sformatf("v%0d perr", idx), 32'(protocol_err_o), 32'(v.e_perr));
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, " rf_we"}, 32'(rf_we_o), 32'd0);
      chk({tag, " level"}, 32'(id_buf_level_o), 32'd0);
      chk({tag, " mask"}, pending_mask_o, 32'd0);
      chk({tag, " perr"}, 32'(protocol_err_o), 32'd0);
      chk({tag, " id_ready"}, 32'(bus.id_wr_ready), 32'd1);
      chk({tag, " load_ready"}, 32'(bus.lsu_load_ready), 32'd1);
   endtask

   // ---------------- test ----------------
   vec_t tbl [$];

   initial begin
      logic [31:0] junk;
      junk = 32'($urandom_range(32'hFFFF, 32'h1000));
      //             id_v id_a id_d          iss iss_a rv re rd           ra rb  we wa wd            idr ldr mask        ha hb lvl perr
      tbl.push_back(mk(1, 5, 32'hA5A5A5A5,  0, 0,    0, 0, 0,           0, 0,  1, 5, 32'hA5A5A5A5, 1, 1, 32'h0,     0, 0, 0, 0)); // 0 direct write
      tbl.push_back(mk(0, 0, 0,             1, 7,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 1 issue x7
      tbl.push_back(mk(1, 3, 32'h22,        0, 0,    1, 0, 32'h11,      7, 3,  1, 7, 32'h11,       1, 1, 32'h80,    1, 0, 0, 0)); // 2 LSU wins
      tbl.push_back(mk(0, 0, 0,             0, 0,    0, 0, 0,           3, 0,  1, 3, 32'h22,       1, 1, 32'h8,     1, 0, 1, 0)); // 3 drain x3
      tbl.push_back(mk(0, 0, 0,             0, 0,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 4
      tbl.push_back(mk(0, 0, 0,             1, 10,   0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 5
      tbl.push_back(mk(0, 0, 0,             1, 11,   0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h400,   0, 0, 0, 0)); // 6
      tbl.push_back(mk(1, 12, 32'h200,      0, 0,    1, 0, 32'h100,     0, 0,  1, 10, 32'h100,     1, 0, 32'hC00,   0, 0, 0, 0)); // 7 collide a
      tbl.push_back(mk(1, 13, 32'h201,      0, 0,    1, 0, 32'h101,     11, 13, 1, 11, 32'h101,    1, 1, 32'h1800,  1, 0, 1, 0)); // 8 collide b
      tbl.push_back(mk(1, 14, 32'h202,      0, 0,    0, 0, 0,           0, 0,  1, 12, 32'h200,     0, 1, 32'h3000,  0, 0, 2, 0)); // 9 full
      tbl.push_back(mk(1, 14, 32'h202,      0, 0,    0, 0, 0,           0, 0,  1, 13, 32'h201,     1, 1, 32'h2000,  0, 0, 1, 0)); // 10
      tbl.push_back(mk(0, 0, 0,             0, 0,    0, 0, 0,           0, 0,  1, 14, 32'h202,     1, 1, 32'h4000,  0, 0, 1, 0)); // 11
      tbl.push_back(mk(0, 0, 0,             0, 0,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 12
      tbl.push_back(mk(0, 0, 0,             1, 4,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 13
      tbl.push_back(mk(0, 0, 0,             1, 9,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h10,    0, 0, 0, 0)); // 14
      tbl.push_back(mk(0, 0, 0,             1, 20,   0, 0, 0,           9, 4,  0, 0, 0,            1, 0, 32'h210,   1, 1, 0, 0)); // 15 issue dropped
      tbl.push_back(mk(0, 0, 0,             0, 0,    1, 1, junk,        0, 0,  0, 0, 0,            1, 0, 32'h210,   0, 0, 0, 0)); // 16 error resp
      tbl.push_back(mk(1, 6, 32'h66,        0, 0,    1, 1, junk,        9, 4,  1, 6, 32'h66,       1, 1, 32'h200,   1, 0, 0, 0)); // 17 err + fallthrough
      tbl.push_back(mk(0, 0, 0,             0, 0,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 18
      tbl.push_back(mk(1, 0, 32'h123,       1, 0,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 19 x0 direct
      tbl.push_back(mk(1, 0, 32'h99,        0, 0,    1, 0, 32'h77,      0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 20 x0 load
      tbl.push_back(mk(0, 0, 0,             0, 0,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 1, 0)); // 21 x0 drain
      tbl.push_back(mk(0, 0, 0,             0, 0,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 22
      tbl.push_back(mk(0, 0, 0,             1, 8,    1, 0, 32'h55,      0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 0)); // 23 resp on empty
      tbl.push_back(mk(0, 0, 0,             0, 0,    1, 0, 32'h88,      8, 0,  1, 8, 32'h88,       1, 1, 32'h100,   1, 0, 0, 1)); // 24
      tbl.push_back(mk(0, 0, 0,             0, 0,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 1)); // 25
      tbl.push_back(mk(0, 0, 0,             1, 1,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h0,     0, 0, 0, 1)); // 26
      tbl.push_back(mk(0, 0, 0,             1, 2,    0, 0, 0,           0, 0,  0, 0, 0,            1, 1, 32'h2,     0, 0, 0, 1)); // 27
      tbl.push_back(mk(1, 15, 32'h41,       0, 0,    1, 0, 32'h31,      0, 0,  1, 1, 32'h31,       1, 0, 32'h6,     0, 0, 0, 1)); // 28
      tbl.push_back(mk(1, 16, 32'h42,       0, 0,    1, 0, 32'h32,      0, 0,  1, 2, 32'h32,       1, 1, 32'h8004,  0, 0, 1, 1)); // 29

      drive_idle();
      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      check_quiet("reset");
      chk("reset haz_a", 32'(hazard_a_o), 32'd0);
      chk("reset haz_b", 32'(hazard_b_o), 32'd0);
      rst_ni = 1'b1;

      foreach (tbl[i]) apply(tbl[i], i);

      // Two entries are buffered now; an asynchronous reset must drop them.
      @(posedge clk_i); #1;
      drive_idle();
      rst_ni = 1'b0;
      @(negedge clk_i);
      check_quiet("midreset");
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check_quiet($sformatf("postreset%0d", i));
      end

      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
